// File: rtl/hazard_controller.sv
// Stall/flush controller for the 5-stage rv32i pipeline: load-use bubbles, memory-wait
// freezes, mispredict flushes, duplicate-request gating and saturating event counters.
module hazard_controller #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           ID_rs1_i,
  input  logic [4:0]           ID_rs2_i,
  input  logic                 ID_uses_rs1_i,
  input  logic                 ID_uses_rs2_i,
  input  logic [4:0]           EX_rd_i,
  input  logic                 EX_mem_read_i,
  input  logic                 EX_mispredict_i,
  input  logic                 imem_read_i,
  input  logic                 imem_resp_i,
  input  logic                 dmem_req_i,
  input  logic                 dmem_resp_i,
  output logic                 imem_read_o,
  output logic                 dmem_req_o,
  output logic                 pc_load_o,
  output logic                 IF_ID_load_o,
  output logic                 ID_EX_load_o,
  output logic                 EX_MEM_load_o,
  output logic                 MEM_WB_load_o,
  output logic                 IF_ID_flush_o,
  output logic                 ID_EX_flush_o,
  output logic [CNT_WIDTH-1:0] stall_cycles_o,
  output logic [CNT_WIDTH-1:0] bubble_count_o,
  output logic [CNT_WIDTH-1:0] flush_count_o
);

  localparam logic [0:0] RUN      = 1'b0;
  localparam logic [0:0] MEM_WAIT = 1'b1;

  logic [0:0] state_q, state_d;
  logic       imem_done_q, dmem_done_q;
  logic       imem_ok, dmem_ok, advance, load_use;
  logic       do_flush, do_bubble;
  logic [CNT_WIDTH-1:0] stall_q, bubble_q, flush_q;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                    input logic en);
    if (en && (v != {CNT_WIDTH{1'b1}}))
      return v + CNT_WIDTH'(1);
    return v;
  endfunction

  assign imem_ok  = ~imem_read_i | imem_resp_i | imem_done_q;
  assign dmem_ok  = ~dmem_req_i  | dmem_resp_i | dmem_done_q;
  assign advance  = imem_ok & dmem_ok;
  assign load_use = EX_mem_read_i & (EX_rd_i != 5'd0) &
                    ((ID_uses_rs1_i & (EX_rd_i == ID_rs1_i)) |
                     (ID_uses_rs2_i & (EX_rd_i == ID_rs2_i)));

  // A mispredict squashes the wrong-path consumer, so it outranks load-use.
  assign do_flush  = advance & EX_mispredict_i;
  assign do_bubble = advance & ~EX_mispredict_i & load_use;

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:      state_d = advance ? RUN : MEM_WAIT;
      MEM_WAIT: state_d = advance ? RUN : MEM_WAIT;
      default:  state_d = RUN;
    endcase
  end

  always_comb begin
    imem_read_o   = 1'b0;
    dmem_req_o    = 1'b0;
    pc_load_o     = 1'b0;
    IF_ID_load_o  = 1'b0;
    ID_EX_load_o  = 1'b0;
    EX_MEM_load_o = 1'b0;
    MEM_WB_load_o = 1'b0;
    IF_ID_flush_o = 1'b0;
    ID_EX_flush_o = 1'b0;
    if (!rst) begin
      imem_read_o = imem_read_i & ~imem_done_q;
      dmem_req_o  = dmem_req_i & ~dmem_done_q;
      if (advance) begin
        pc_load_o     = ~do_bubble;
        IF_ID_load_o  = ~do_bubble;
        ID_EX_load_o  = 1'b1;
        EX_MEM_load_o = 1'b1;
        MEM_WB_load_o = 1'b1;
        IF_ID_flush_o = do_flush;
        ID_EX_flush_o = do_flush | do_bubble;
      end
    end
  end

  // Done flags remember a response that arrived while the other side still stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      imem_done_q <= 1'b0;
      dmem_done_q <= 1'b0;
      stall_q     <= '0;
      bubble_q    <= '0;
      flush_q     <= '0;
    end else begin
      state_q     <= state_d;
      imem_done_q <= advance ? 1'b0 : (imem_done_q | imem_resp_i);
      dmem_done_q <= advance ? 1'b0 : (dmem_done_q | dmem_resp_i);
      stall_q     <= sat_inc(stall_q, ~advance);
      bubble_q    <= sat_inc(bubble_q, do_bubble);
      flush_q     <= sat_inc(flush_q, do_flush);
    end
  end

  assign stall_cycles_o = stall_q;
  assign bubble_count_o = bubble_q;
  assign flush_count_o  = flush_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed-vector bench for hazard_controller; a CNT_WIDTH=4 copy shares the inputs
// so counter saturation can be observed.
module tb_hazard_controller;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] ID_rs1_i, ID_rs2_i, EX_rd_i;
  logic ID_uses_rs1_i, ID_uses_rs2_i, EX_mem_read_i, EX_mispredict_i;
  logic imem_read_i, imem_resp_i, dmem_req_i, dmem_resp_i;

  logic imem_read_o, dmem_req_o, pc_load_o, IF_ID_load_o, ID_EX_load_o;
  logic EX_MEM_load_o, MEM_WB_load_o, IF_ID_flush_o, ID_EX_flush_o;
  logic [31:0] stall_cycles_o, bubble_count_o, flush_count_o;

  logic s_imem_read_o, s_dmem_req_o, s_pc_load_o, s_IF_ID_load_o, s_ID_EX_load_o;
  logic s_EX_MEM_load_o, s_MEM_WB_load_o, s_IF_ID_flush_o, s_ID_EX_flush_o;
  logic [3:0] s_stall_cycles_o, s_bubble_count_o, s_flush_count_o;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  hazard_controller #(.CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .ID_rs1_i(ID_rs1_i), .ID_rs2_i(ID_rs2_i),
    .ID_uses_rs1_i(ID_uses_rs1_i), .ID_uses_rs2_i(ID_uses_rs2_i),
    .EX_rd_i(EX_rd_i), .EX_mem_read_i(EX_mem_read_i), .EX_mispredict_i(EX_mispredict_i),
    .imem_read_i(imem_read_i), .imem_resp_i(imem_resp_i),
    .dmem_req_i(dmem_req_i), .dmem_resp_i(dmem_resp_i),
    .imem_read_o(imem_read_o), .dmem_req_o(dmem_req_o),
    .pc_load_o(pc_load_o), .IF_ID_load_o(IF_ID_load_o), .ID_EX_load_o(ID_EX_load_o),
    .EX_MEM_load_o(EX_MEM_load_o), .MEM_WB_load_o(MEM_WB_load_o),
    .IF_ID_flush_o(IF_ID_flush_o), .ID_EX_flush_o(ID_EX_flush_o),
    .stall_cycles_o(stall_cycles_o), .bubble_count_o(bubble_count_o),
    .flush_count_o(flush_count_o)
  );

  hazard_controller #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst),
    .ID_rs1_i(ID_rs1_i), .ID_rs2_i(ID_rs2_i),
    .ID_uses_rs1_i(ID_uses_rs1_i), .ID_uses_rs2_i(ID_uses_rs2_i),
    .EX_rd_i(EX_rd_i), .EX_mem_read_i(EX_mem_read_i), .EX_mispredict_i(EX_mispredict_i),
    .imem_read_i(imem_read_i), .imem_resp_i(imem_resp_i),
    .dmem_req_i(dmem_req_i), .dmem_resp_i(dmem_resp_i),
    .imem_read_o(s_imem_read_o), .dmem_req_o(s_dmem_req_o),
    .pc_load_o(s_pc_load_o), .IF_ID_load_o(s_IF_ID_load_o), .ID_EX_load_o(s_ID_EX_load_o),
    .EX_MEM_load_o(s_EX_MEM_load_o), .MEM_WB_load_o(s_MEM_WB_load_o),
    .IF_ID_flush_o(s_IF_ID_flush_o), .ID_EX_flush_o(s_ID_EX_flush_o),
    .stall_cycles_o(s_stall_cycles_o), .bubble_count_o(s_bubble_count_o),
    .flush_count_o(s_flush_count_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ID_rs1_i = 5'd0; ID_rs2_i = 5'd0; ID_uses_rs1_i = 1'b0; ID_uses_rs2_i = 1'b0;
    EX_rd_i = 5'd0; EX_mem_read_i = 1'b0; EX_mispredict_i = 1'b0;
    imem_read_i = 1'b0; imem_resp_i = 1'b0; dmem_req_i = 1'b0; dmem_resp_i = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                              input logic [4:0] rs2, input logic u2);
    EX_mem_read_i = 1'b1; EX_rd_i = rd;
    ID_rs1_i = rs1; ID_uses_rs1_i = u1; ID_rs2_i = rs2; ID_uses_rs2_i = u2;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    // Outputs forced low during reset even with active requests and a mispredict.
    imem_read_i = 1'b1; dmem_req_i = 1'b1; EX_mispredict_i = 1'b1;
    tick(); tick();
    check("rst_imem_read_o", imem_read_o, 0);
    check("rst_dmem_req_o", dmem_req_o, 0);
    check("rst_pc_load", pc_load_o, 0);
    check("rst_IF_ID_flush", IF_ID_flush_o, 0);
    check("rst_stall_cnt", stall_cycles_o, 0);
    check("rst_flush_cnt", flush_count_o, 0);
    idle_inputs();
    rst = 1'b0;
    #1;
    check("idle_pc_load", pc_load_o, 1);
    check("idle_ID_EX_flush", ID_EX_flush_o, 0);

    // Load-use: lw x5 in EX, add x6,x5,x1 in ID.
    set_load_use(5'd5, 5'd5, 1'b1, 5'd1, 1'b1);
    #1;
    check("lu_pc_load", pc_load_o, 0);
    check("lu_IF_ID_load", IF_ID_load_o, 0);
    check("lu_ID_EX_load", ID_EX_load_o, 1);
    check("lu_ID_EX_flush", ID_EX_flush_o, 1);
    check("lu_IF_ID_flush", IF_ID_flush_o, 0);
    check("lu_EX_MEM_load", EX_MEM_load_o, 1);
    tick();
    check("lu_bubble_cnt", bubble_count_o, 1);
    EX_mem_read_i = 1'b0;
    #1;
    check("lu_after_pc_load", pc_load_o, 1);
    check("lu_after_ID_EX_flush", ID_EX_flush_o, 0);
    tick();
    // rd = x0 never creates a hazard.
    set_load_use(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
    #1;
    check("x0_pc_load", pc_load_o, 1);
    check("x0_ID_EX_flush", ID_EX_flush_o, 0);
    tick();
    check("x0_bubble_cnt", bubble_count_o, 1);
    // rs2 match.
    set_load_use(5'd7, 5'd3, 1'b1, 5'd7, 1'b1);
    #1;
    check("rs2_IF_ID_load", IF_ID_load_o, 0);
    tick();
    check("rs2_bubble_cnt", bubble_count_o, 2);
    // Same register but operand not used.
    set_load_use(5'd7, 5'd3, 1'b1, 5'd7, 1'b0);
    #1;
    check("unused_pc_load", pc_load_o, 1);
    tick();
    check("unused_bubble_cnt", bubble_count_o, 2);

    // Mispredict outranks a concurrent load-use.
    do_reset();
    set_load_use(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    EX_mispredict_i = 1'b1;
    #1;
    check("mp_IF_ID_flush", IF_ID_flush_o, 1);
    check("mp_ID_EX_flush", ID_EX_flush_o, 1);
    check("mp_pc_load", pc_load_o, 1);
    check("mp_IF_ID_load", IF_ID_load_o, 1);
    check("mp_MEM_WB_load", MEM_WB_load_o, 1);
    tick();
    check("mp_flush_cnt", flush_count_o, 1);
    check("mp_bubble_cnt", bubble_count_o, 0);

    // Split responses: imem at cycle 2, dmem at cycle 5.
    do_reset();
    imem_read_i = 1'b1; dmem_req_i = 1'b1;
    for (int c = 0; c <= 6; c++) begin
      imem_resp_i = (c == 2);
      dmem_resp_i = (c == 5);
      #1;
      if (c < 5) begin
        check($sformatf("split_pc_load_c%0d", c), pc_load_o, 0);
        check($sformatf("split_MEM_WB_load_c%0d", c), MEM_WB_load_o, 0);
      end
      if (c >= 3 && c <= 5) check($sformatf("split_imem_read_o_c%0d", c), imem_read_o, 0);
      if (c <= 2) check($sformatf("split_imem_read_o_c%0d", c), imem_read_o, 1);
      if (c <= 5) check($sformatf("split_dmem_req_o_c%0d", c), dmem_req_o, 1);
      if (c == 5) check("split_advance_pc_load", pc_load_o, 1);
      if (c == 6) begin
        check("split_stall_cnt", stall_cycles_o, 5);
        check("split_imem_flag_clear", imem_read_o, 1);
        check("split_dmem_flag_clear", dmem_req_o, 1);
      end
      tick();
    end

    // Load-use held through a 3-cycle freeze: one bubble on release.
    do_reset();
    set_load_use(5'd9, 5'd9, 1'b1, 5'd0, 1'b0);
    dmem_req_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("frz_ID_EX_flush_c%0d", c), ID_EX_flush_o, 0);
      check($sformatf("frz_ID_EX_load_c%0d", c), ID_EX_load_o, 0);
      tick();
    end
    check("frz_bubble_cnt_held", bubble_count_o, 0);
    dmem_resp_i = 1'b1;
    #1;
    check("frz_rel_ID_EX_flush", ID_EX_flush_o, 1);
    check("frz_rel_pc_load", pc_load_o, 0);
    check("frz_rel_ID_EX_load", ID_EX_load_o, 1);
    tick();
    check("frz_bubble_cnt", bubble_count_o, 1);
    check("frz_stall_cnt", stall_cycles_o, 3);

    // Reset during MEM_WAIT with the imem done flag set.
    do_reset();
    imem_read_i = 1'b1; dmem_req_i = 1'b1; imem_resp_i = 1'b1;
    tick();
    imem_resp_i = 1'b0;
    #1;
    check("mr_imem_gated", imem_read_o, 0);
    rst = 1'b1;
    #1;
    check("mr_rst_imem_read_o", imem_read_o, 0);
    check("mr_rst_EX_MEM_load", EX_MEM_load_o, 0);
    tick();
    rst = 1'b0;
    #1;
    check("mr_imem_read_o", imem_read_o, 1);
    check("mr_stall_cnt", stall_cycles_o, 0);
    check("mr_pc_load_frozen", pc_load_o, 0);

    // Saturation on the 4-bit copy.
    do_reset();
    dmem_req_i = 1'b1;
    for (int c = 0; c < 20; c++) tick();
    check("sat4_stall_cnt", s_stall_cycles_o, 15);
    check("sat32_stall_cnt", stall_cycles_o, 20);
    tick(); tick();
    check("sat4_stall_held", s_stall_cycles_o, 15);

    idle_inputs();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
